// File: rtl/detect_pkg.sv
// Shared constants and run-FSM encoding for the detect_monitor block.
package detect_pkg;
   localparam logic IDLE      = 1'b0;
   localparam logic RUN       = 1'b1;
   localparam int   ONEHOT_W  = 5;
   localparam int   DEF_CNT_W = 8;
   localparam int   DEF_RUN_W = 8;

   typedef enum logic {
      S_IDLE = IDLE,
      S_RUN  = RUN
   } run_state_e;
endpackage

// File: rtl/detect_monitor_onehot_check.sv
// Combinational legality check: valid_o is high iff exactly one input bit is set.
module onehot_check
   import detect_pkg::*;
(
   input  logic [ONEHOT_W-1:0] vec_i,
   output logic                valid_o
);
   assign valid_o = ($countones(vec_i) == 1);
endmodule

// File: rtl/detect_monitor.sv
// Monitor for the upstream sequence detector: counts z rising edges, tracks run
// lengths, strobes on each new detection and latches illegal state vectors.
module detect_monitor
   import detect_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int RUN_W    = DEF_RUN_W,
   parameter bit SATURATE = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                z,
   input  logic [ONEHOT_W-1:0] states,
   output logic                pulse,
   output logic [CNT_W-1:0]    detect_count,
   output logic [RUN_W-1:0]    current_run,
   output logic [RUN_W-1:0]    max_run,
   output logic                run_active,
   output logic                onehot_err
);
   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [RUN_W-1:0] max_q, max_d;
   logic             pulse_q, pulse_d;
   logic             err_q, err_d;
   logic             states_ok;
   logic             rise;

   onehot_check u_onehot_check (
      .vec_i   (states),
      .valid_o (states_ok)
   );

   always_comb begin
      state_d = state_q;
      rise    = 1'b0;
      case (state_q)
         S_IDLE: if (z) begin
            state_d = S_RUN;
            rise    = 1'b1;
         end
         S_RUN: if (!z) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      cnt_d = cnt_q;
      if (rise) begin
         if (cnt_q == '1) cnt_d = SATURATE ? cnt_q : '0;
         else             cnt_d = cnt_q + 1'b1;
      end

      if (!z)              run_d = '0;
      else if (run_q == '1) run_d = run_q;
      else                 run_d = run_q + 1'b1;

      // Compare against the next run value so a record run shows up in max_run immediately.
      max_d   = (run_d > max_q) ? run_d : max_q;
      pulse_d = rise;
      err_d   = err_q | ~states_ok;

      // Clear wipes the statistics but the FSM keeps following z, so a held-high z
      // does not produce a fresh edge once clear drops.
      if (clear) begin
         cnt_d   = '0;
         run_d   = '0;
         max_d   = '0;
         pulse_d = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         run_q   <= '0;
         max_q   <= '0;
         pulse_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         max_q   <= max_d;
         pulse_q <= pulse_d;
         err_q   <= err_d;
      end
   end

   assign pulse        = pulse_q;
   assign detect_count = cnt_q;
   assign current_run  = run_q;
   assign max_run      = max_q;
   assign run_active   = (state_q == S_RUN);
   assign onehot_err   = err_q;
endmodule

// File: tb/tb_detect_monitor.sv
// Bench for detect_monitor: three parameterisations share one stimulus stream and
// are checked every cycle against a behavioural model, plus directed end-point checks.
module tb_detect_monitor;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clear = 1'b0;
   logic       z = 1'b0;
   logic [4:0] states = 5'b00001;

   logic       p0, p1, p2, a0, a1, a2, e0, e1, e2;
   logic [7:0] c0, r0, m0;
   logic [3:0] c1, r1, m1, c2, r2, m2;

   int errors = 0;
   int checks = 0;

   // Model state: index 0 = 8/8 saturating, 1 = 4/4 saturating, 2 = 4/4 wrapping
   int m_cnt[3], m_run[3], m_max[3], m_pulse[3], m_err[3], m_inrun[3];
   int maxc[3] = '{255, 15, 15};
   int maxr[3] = '{255, 15, 15};
   int sat[3]  = '{1, 1, 0};

   always #5 clk = ~clk;

   detect_monitor #(.CNT_W(8), .RUN_W(8), .SATURATE(1'b1)) dut0 (
      .clk(clk), .reset(reset), .clear(clear), .z(z), .states(states),
      .pulse(p0), .detect_count(c0), .current_run(r0), .max_run(m0),
      .run_active(a0), .onehot_err(e0));
   detect_monitor #(.CNT_W(4), .RUN_W(4), .SATURATE(1'b1)) dut1 (
      .clk(clk), .reset(reset), .clear(clear), .z(z), .states(states),
      .pulse(p1), .detect_count(c1), .current_run(r1), .max_run(m1),
      .run_active(a1), .onehot_err(e1));
   detect_monitor #(.CNT_W(4), .RUN_W(4), .SATURATE(1'b0)) dut2 (
      .clk(clk), .reset(reset), .clear(clear), .z(z), .states(states),
      .pulse(p2), .detect_count(c2), .current_run(r2), .max_run(m2),
      .run_active(a2), .onehot_err(e2));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Model works from the observable rules: an edge is z high after a cycle not in a run.
   task automatic model_step(input int k);
      int bits;
      bits = $countones(states);
      if (!reset) begin
         m_cnt[k] = 0; m_run[k] = 0; m_max[k] = 0;
         m_pulse[k] = 0; m_err[k] = 0; m_inrun[k] = 0;
      end else if (clear) begin
         m_cnt[k] = 0; m_run[k] = 0; m_max[k] = 0;
         m_pulse[k] = 0; m_err[k] = 0; m_inrun[k] = z;
      end else begin
         m_pulse[k] = (z && !m_inrun[k]) ? 1 : 0;
         if (m_pulse[k] == 1)
            m_cnt[k] = (m_cnt[k] < maxc[k]) ? m_cnt[k] + 1 : (sat[k] ? maxc[k] : 0);
         m_run[k] = z ? ((m_run[k] + 1 > maxr[k]) ? maxr[k] : m_run[k] + 1) : 0;
         if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
         if (bits != 1) m_err[k] = 1;
         m_inrun[k] = z;
      end
   endtask

   task automatic chk_dut(input int k, input int cnt, input int run, input int mx,
                          input int pl, input int act, input int er);
      chk($sformatf("dut%0d.detect_count", k), cnt, m_cnt[k]);
      chk($sformatf("dut%0d.current_run", k), run, m_run[k]);
      chk($sformatf("dut%0d.max_run", k), mx, m_max[k]);
      chk($sformatf("dut%0d.pulse", k), pl, m_pulse[k]);
      chk($sformatf("dut%0d.run_active", k), act, m_inrun[k]);
      chk($sformatf("dut%0d.onehot_err", k), er, m_err[k]);
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
      chk_dut(0, int'(c0), int'(r0), int'(m0), int'(p0), int'(a0), int'(e0));
      chk_dut(1, int'(c1), int'(r1), int'(m1), int'(p1), int'(a1), int'(e1));
      chk_dut(2, int'(c2), int'(r2), int'(m2), int'(p2), int'(a2), int'(e2));
   endtask

   initial begin
      int np;
      logic [6:0] pat;
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0; m_run[k] = 0; m_max[k] = 0;
         m_pulse[k] = 0; m_err[k] = 0; m_inrun[k] = 0;
      end

      // Reset held with z high and an illegal state vector
      reset = 1'b0; z = 1'b1; states = 5'b00000;
      tick(); tick();
      chk("rst.count", int'(c0), 0);
      chk("rst.run", int'(r0), 0);
      chk("rst.active", int'(a0), 0);
      chk("rst.err", int'(e0), 0);

      // Release with z high: first edge seen one cycle later
      reset = 1'b1; states = 5'b00001;
      tick();
      chk("rel.pulse", int'(p0), 1);
      chk("rel.count", int'(c0), 1);
      chk("rel.run", int'(r0), 1);

      z = 1'b0; tick();
      clear = 1'b1; tick(); clear = 1'b0;

      // Run lengths: 1,1,1,0,1,1,0
      pat = 7'b0110111;
      np = 0;
      for (int i = 0; i < 7; i++) begin
         z = pat[i]; states = 5'b00001 << (i % 5);
         tick();
         np += int'(p0);
      end
      chk("runs.count", int'(c0), 2);
      chk("runs.pulses", np, 2);
      chk("runs.max", int'(m0), 3);
      chk("runs.cur", int'(r0), 0);

      // Counter saturation and wrap on the narrow instances
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 20; i++) begin
         z = 1'b1; tick();
         z = 1'b0; tick();
      end
      chk("sat.count", int'(c1), 15);
      chk("wrap.count", int'(c2), 4);
      chk("wide.count", int'(c0), 20);

      // Run saturation
      clear = 1'b1; tick(); clear = 1'b0;
      z = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("runsat.cur", int'(r1), 15);
      chk("runsat.max", int'(m1), 15);
      chk("runsat.wide", int'(r0), 20);

      // One-hot error is sticky until clear
      z = 1'b0; tick();
      clear = 1'b1; tick(); clear = 1'b0;
      states = 5'b00011; tick();
      chk("err.set", int'(e0), 1);
      states = 5'b00001; tick();
      chk("err.sticky", int'(e0), 1);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("err.clear", int'(e0), 0);

      // Clear in the middle of a run
      z = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      clear = 1'b1; tick(); clear = 1'b0;
      np = 0;
      tick(); np += int'(p0);
      tick(); np += int'(p0);
      chk("midclr.count", int'(c0), 0);
      chk("midclr.max", int'(m0), 2);
      chk("midclr.pulses", np, 0);

      // Reset wins over clear during a run
      reset = 1'b0; clear = 1'b1; tick();
      chk("rvc.active", int'(a0), 0);
      chk("rvc.max", int'(m0), 0);
      chk("rvc.run", int'(r0), 0);
      reset = 1'b1; clear = 1'b0;

      // Randomised traffic, checked cycle by cycle against the model
      for (int i = 0; i < 400; i++) begin
         z      = ($urandom_range(0, 99) < 60);
         clear  = ($urandom_range(0, 29) == 0);
         reset  = ($urandom_range(0, 59) != 0);
         states = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31))
                                               : 5'(5'b00001 << $urandom_range(0, 4));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/detect_monitor.md
Name: detect_monitor

Overview:
- Downstream consumer of the five-state one-hot sequence-detector FSM; takes its `z` detection output and its 5-bit one-hot `states` vector.
- Counts detection events (rising edges of `z`) and measures the current and longest run of consecutive `z`-high cycles.
- Emits a one-cycle detect pulse and flags any illegal (non-one-hot) state vector with a sticky bit.
- Results drive board LEDs/displays in the lab top level.

Parameters:
- CNT_W, 8: width of detect_count.
- RUN_W, 8: width of current_run and max_run.
- SATURATE, 1: 1 = detect_count saturates at all-ones; 0 = detect_count wraps to 0.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- clear  in  1  synchronous clear of counters and error flag, active-high.
- z  in  1  detection output from the upstream FSM.
- states  in  5  one-hot state vector from the upstream FSM, {E,D,C,B,A}.
- pulse  out  1  registered one-cycle strobe on each z rising edge.
- detect_count  out  CNT_W  number of z rising edges since reset/clear.
- current_run  out  RUN_W  consecutive cycles z has been sampled high; 0 when z is low.
- max_run  out  RUN_W  largest current_run value since reset/clear.
- run_active  out  1  1 while the run FSM is in RUN.
- onehot_err  out  1  sticky; set when states is not exactly one-hot.

Behaviour:
- Reset, the only asynchronous-free path: on a clk edge with reset=0, all outputs and internal state go to 0 and the run FSM goes to IDLE. This overrides clear and all inputs.
- Priority at each edge: reset > clear > normal update.
- Run FSM, two states:
  - IDLE: z=1 -> RUN, rising edge detected.
  - RUN: z=0 -> IDLE.
  - run_active = (state == RUN).
- Rising edge means z=1 sampled while the FSM is in IDLE. At that same edge:
  - pulse <= 1, so pulse is high for exactly the following cycle (latency 1).
  - detect_count <= detect_count+1. If SATURATE=1 and the count is all-ones, it holds. If SATURATE=0, it wraps to 0.
- pulse <= 0 on every edge that is not a rising edge.
- current_run:
  - z sampled 1: current_run <= current_run+1, saturating at all-ones.
  - z sampled 0: current_run <= 0.
- max_run:
  - On the same edge, if the new current_run value exceeds max_run, max_run takes the new value.
  - Compare against the next value, not the registered one. max_run therefore equals current_run in the same cycle while a record run is growing.
  - Saturates with current_run; never decreases except on reset or clear.
- onehot_err:
  - Set at any edge where the sampled states has popcount != 1 (00000, or two or more bits high).
  - Stays set until reset or clear. Does not block counting.
- clear=1 (with reset=1):
  - detect_count, current_run, max_run, pulse and onehot_err go to 0.
  - The FSM state still tracks z: RUN if z=1, else IDLE.
  - Consequence: z held high across a clear produces no new edge afterwards.
- Reset or clear mid-run: the run in progress is discarded and is not retro-credited to max_run.
- Every output is a register output. No combinational path from inputs to outputs.

Decomposition:
- Package detect_pkg:
  - Localparams IDLE=1'b0, RUN=1'b1.
  - ONEHOT_W=5.
  - Default CNT_W/RUN_W values.
- One sub-module: onehot_check (combinational). Input a 5-bit vector; output valid=1 iff exactly one bit is set. Instantiated once on states.

Test Plan:
- Reset and clear:
  - reset=0 for 2 cycles with z=1 and states=00000 -> all outputs 0, run_active=0.
  - Release reset with z=1 -> next cycle pulse=1, detect_count=1, current_run=1.
- Run lengths:
  - z pattern 1,1,1,0,1,1,0 (states legal) -> detect_count=2, pulse high on two cycles only, max_run=3, current_run=0 at end.
- Saturation, CNT_W=4:
  - SATURATE=1, 20 isolated z pulses -> detect_count=15.
  - SATURATE=0, 20 isolated z pulses -> detect_count=4.
  - RUN_W=4 with z high for 20 cycles -> current_run=max_run=15.
- One-hot error:
  - states=00011 for one cycle -> onehot_err=1 next cycle; stays 1 after states returns to 00001.
  - clear=1 -> onehot_err=0.
- Clear mid-run:
  - z high 5 cycles, pulse clear while z=1, z stays high 2 more cycles -> detect_count=0, max_run=2, no pulse after clear.
- Reset vs clear:
  - reset=0 and clear=1 in the same cycle during a run -> state equals post-reset values, run_active=0 even with z=1.
